adxl362_spi_master: RTL and testbench

Drives the ADXL362 accelerometer on the Nexys A7 over SPI, clocked by the 4 MHz clock from the on-board clock-generation stage. After reset and a power-up wait it writes POWER_CTL to enter measurement mode. It then burst-reads X/Y/Z at a fixed sample rate and presents 12-bit two's-complement samples with a one-cycle valid strobe. It sits between the clock generator and the display/processing logic.

---
 rtl/adxl362_pkg.sv | 46 ++++
 rtl/adxl362_spi_master_spi_byte_engine.sv | 66 ++++++
 rtl/adxl362_spi_master.sv | 129 ++++++++++++
 tb/tb_adxl362_spi_master.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_pkg.sv
// Shared constants and state type for the ADXL362 SPI master.
// Sensor command/register codes, SPI framing timing and the transaction byte table.
package adxl362_pkg;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_XDATA_L   = 8'h0E;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;

    localparam int BIT_CYCLES  = 4;
    localparam int CS_SETUP    = 4;
    localparam int CS_HOLD     = 4;
    localparam int CS_GAP      = 4;
    localparam int BYTE_CYCLES = 8 * BIT_CYCLES;
    localparam int CFG_BYTES   = 3;
    localparam int READ_BYTES  = 8;
    localparam int CFG_LAST    = CS_SETUP + CFG_BYTES * BYTE_CYCLES + CS_HOLD - 1;
    localparam int READ_LAST   = CS_SETUP + READ_BYTES * BYTE_CYCLES + CS_HOLD - 1;
    localparam int MIN_READ_PERIOD = READ_LAST + 1 + CS_GAP;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_CFG,
        ST_GAP,
        ST_WAIT,
        ST_READ,
        ST_UPDATE
    } state_t;

    // Byte to transmit at position idx of a config write or burst read.
    function automatic logic [7:0] tx_byte_for(input logic is_read, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (is_read) begin
            if (idx == 4'd0)      b = CMD_READ;
            else if (idx == 4'd1) b = REG_XDATA_L;
        end else begin
            if (idx == 4'd0)      b = CMD_WRITE;
            else if (idx == 4'd1) b = REG_POWER_CTL;
            else if (idx == 4'd2) b = PWR_MEASURE;
        end
        return b;
    endfunction

endpackage

// File: rtl/adxl362_spi_master_spi_byte_engine.sv
// Mode-0 SPI byte shifter: four-phase bit cell, MSB first, MISO sampled as SCLK falls.
module spi_byte_engine
    import adxl362_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       mosi
);

    logic       busy;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [6:0] tx_shift;
    logic [6:0] rx_shift;
    logic [7:0] rx_next;
    logic       bit_end;

    assign bit_end = busy && (phase == 2'd3);
    assign rx_next = {rx_shift, miso};

    // A start coinciding with the last bit's end chains the next byte with no idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            tx_shift <= 7'd0;
            rx_shift <= 7'd0;
            rx_byte  <= 8'd0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            sclk <= busy && (phase == 2'd1 || phase == 2'd2);
            if (busy) phase <= phase + 2'd1;
            if (bit_end) begin
                rx_shift <= rx_next[6:0];
                if (bit_cnt == 3'd7) begin
                    done    <= 1'b1;
                    rx_byte <= rx_next;
                    busy    <= 1'b0;
                    mosi    <= 1'b0;
                end else begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    mosi     <= tx_shift[6];
                    tx_shift <= {tx_shift[5:0], 1'b0};
                end
            end
            if (start) begin
                busy     <= 1'b1;
                phase    <= 2'd0;
                bit_cnt  <= 3'd0;
                tx_shift <= tx_byte[6:0];
                mosi     <= tx_byte[7];
            end
        end
    end

endmodule

// File: rtl/adxl362_spi_master.sv
// ADXL362 controller: power-up wait, POWER_CTL write, then periodic X/Y/Z burst reads.
module adxl362_spi_master
    import adxl362_pkg::*;
#(
    parameter int STARTUP_CYCLES = 24000,
    parameter int SAMPLE_DIV     = 40000
) (
    input  logic        clk_4MHz,
    input  logic        CPU_RESETN,
    input  logic        ACL_MISO,
    output logic        ACL_SCLK,
    output logic        ACL_MOSI,
    output logic        ACL_CSN,
    output logic [11:0] acl_x,
    output logic [11:0] acl_y,
    output logic [11:0] acl_z,
    output logic        data_valid,
    output logic        cfg_done
);

    localparam int PERIOD = (SAMPLE_DIV > MIN_READ_PERIOD) ? SAMPLE_DIV : MIN_READ_PERIOD;

    state_t      state, next_state;
    logic [31:0] startup_cnt;
    logic [31:0] tmr;
    logic [8:0]  tcnt;
    logic [2:0]  hi_cnt;
    logic        first_read;
    logic [7:0]  sample_buf [6];

    logic        is_read, in_xact, xact_end, gap_ok, sample_due;
    logic [8:0]  byte_pos;
    logic [3:0]  byte_idx, n_bytes;
    logic        start, done;
    logic [7:0]  tx_byte, rx_byte;
    logic        csn_next, load_sample, cfg_finish;

    assign is_read    = (state == ST_READ);
    assign in_xact    = (state == ST_CFG) || is_read;
    assign n_bytes    = is_read ? 4'(READ_BYTES) : 4'(CFG_BYTES);
    assign xact_end   = tcnt == (is_read ? 9'(READ_LAST) : 9'(CFG_LAST));
    assign gap_ok     = hi_cnt >= 3'(CS_GAP - 1);
    assign sample_due = first_read || (tmr == 32'(PERIOD - 1));

    // Byte k starts one cycle before its first phase; BYTE_CYCLES is 32 so the low 5 bits give the offset.
    assign byte_pos = tcnt - 9'(CS_SETUP - 1);
    assign byte_idx = byte_pos[8:5];
    assign start    = in_xact && (tcnt >= 9'(CS_SETUP - 1)) && (byte_pos[4:0] == 5'd0)
                      && (byte_idx < n_bytes);
    assign tx_byte  = tx_byte_for(is_read, byte_idx);

    spi_byte_engine u_engine (
        .clk     (clk_4MHz),
        .rst_n   (CPU_RESETN),
        .start   (start),
        .tx_byte (tx_byte),
        .miso    (ACL_MISO),
        .done    (done),
        .rx_byte (rx_byte),
        .sclk    (ACL_SCLK),
        .mosi    (ACL_MOSI)
    );

    always_ff @(posedge clk_4MHz or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= ST_STARTUP;
        else             state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_STARTUP: if (startup_cnt == 32'(STARTUP_CYCLES - 1)) next_state = ST_CFG;
            ST_CFG:     if (xact_end) next_state = ST_GAP;
            ST_GAP:     if (gap_ok) next_state = sample_due ? ST_READ : ST_WAIT;
            ST_WAIT:    if (sample_due) next_state = ST_READ;
            ST_READ:    if (xact_end) next_state = ST_UPDATE;
            ST_UPDATE:  next_state = ST_GAP;
            default:    next_state = ST_STARTUP;
        endcase
    end

    always_comb begin
        csn_next    = !(next_state == ST_CFG || next_state == ST_READ);
        load_sample = (next_state == ST_UPDATE);
        cfg_finish  = (state == ST_CFG) && (next_state == ST_GAP);
    end

    // The sample timer restarts at every CSN fall so the read period is measured fall to fall.
    always_ff @(posedge clk_4MHz or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            startup_cnt <= 32'd0;
            tmr         <= 32'd0;
            tcnt        <= 9'd0;
            hi_cnt      <= 3'd0;
            first_read  <= 1'b1;
            for (int i = 0; i < 6; i++) sample_buf[i] <= 8'd0;
        end else begin
            startup_cnt <= (state == ST_STARTUP) ? startup_cnt + 32'd1 : 32'd0;
            tcnt        <= (in_xact && next_state == state) ? tcnt + 9'd1 : 9'd0;
            hi_cnt      <= !ACL_CSN ? 3'd0 : (gap_ok ? hi_cnt : hi_cnt + 3'd1);
            if ((!is_read && next_state == ST_READ) || tmr == 32'(PERIOD - 1)) tmr <= 32'd0;
            else tmr <= tmr + 32'd1;
            if (next_state == ST_READ) first_read <= 1'b0;
            if (done && is_read && byte_idx >= 4'd3)
                sample_buf[3'(byte_idx - 4'd3)] <= rx_byte;
        end
    end

    always_ff @(posedge clk_4MHz or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ACL_CSN    <= 1'b1;
            data_valid <= 1'b0;
            cfg_done   <= 1'b0;
            acl_x      <= 12'd0;
            acl_y      <= 12'd0;
            acl_z      <= 12'd0;
        end else begin
            ACL_CSN    <= csn_next;
            data_valid <= load_sample;
            if (cfg_finish) cfg_done <= 1'b1;
            if (load_sample) begin
                acl_x <= {sample_buf[1][3:0], sample_buf[0]};
                acl_y <= {sample_buf[3][3:0], sample_buf[2]};
                acl_z <= {sample_buf[5][3:0], sample_buf[4]};
            end
        end
    end

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Directed bench for adxl362_spi_master with behavioural mode-0 sensor models.
// dut_a runs at SAMPLE_DIV=1000, dut_b at SAMPLE_DIV=100 (back-to-back reads).
module tb_adxl362_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        miso_a, sclk_a, mosi_a, csn_a, valid_a, cfg_a;
    logic        miso_b, sclk_b, mosi_b, csn_b, valid_b, cfg_b;
    logic [11:0] x_a, y_a, z_a, x_b, y_b, z_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] frame_a = 64'h0000_3402_F00F_0008;
    logic [63:0] frame_b = 64'h0000_9AF5_6603_FF0F;
    int          pos_a = 0;
    int          pos_b = 0;
    logic [23:0] mosi_cap_a = 24'd0;
    int          rises_a = 0;
    int          falls_b [8];
    int          rises_b [8];
    int          nfb = 0;
    int          nrb = 0;
    logic        csn_b_prev = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    adxl362_spi_master #(.STARTUP_CYCLES(100), .SAMPLE_DIV(1000)) dut_a (
        .clk_4MHz(clk), .CPU_RESETN(rst_n), .ACL_MISO(miso_a), .ACL_SCLK(sclk_a),
        .ACL_MOSI(mosi_a), .ACL_CSN(csn_a), .acl_x(x_a), .acl_y(y_a), .acl_z(z_a),
        .data_valid(valid_a), .cfg_done(cfg_a)
    );

    adxl362_spi_master #(.STARTUP_CYCLES(100), .SAMPLE_DIV(100)) dut_b (
        .clk_4MHz(clk), .CPU_RESETN(rst_n), .ACL_MISO(miso_b), .ACL_SCLK(sclk_b),
        .ACL_MOSI(mosi_b), .ACL_CSN(csn_b), .acl_x(x_b), .acl_y(y_b), .acl_z(z_b),
        .data_valid(valid_b), .cfg_done(cfg_b)
    );

    // Sensor models: MSB of the frame is driven while CSN is low, next bit after each SCLK fall.
    always @(posedge csn_a or negedge sclk_a) begin
        if (csn_a) pos_a = 0;
        else       pos_a = pos_a + 1;
    end
    always @(posedge csn_b or negedge sclk_b) begin
        if (csn_b) pos_b = 0;
        else       pos_b = pos_b + 1;
    end
    assign miso_a = (pos_a < 64) ? frame_a[6'(63 - pos_a)] : 1'b0;
    assign miso_b = (pos_b < 64) ? frame_b[6'(63 - pos_b)] : 1'b0;

    always @(negedge csn_a or posedge sclk_a) begin
        if (sclk_a) begin
            mosi_cap_a = {mosi_cap_a[22:0], mosi_a};
            rises_a    = rises_a + 1;
        end else begin
            mosi_cap_a = 24'd0;
            rises_a    = 0;
        end
    end

    always @(negedge clk) begin
        if (csn_b_prev && !csn_b && nfb < 8) begin
            falls_b[nfb] = cyc;
            nfb = nfb + 1;
        end
        if (!csn_b_prev && csn_b && nrb < 8 && rst_n) begin
            rises_b[nrb] = cyc;
            nrb = nrb + 1;
        end
        csn_b_prev = csn_b;
    end

    task automatic wait_csn_a(input logic level, input int limit, output int at);
        int n = 0;
        while (csn_a !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        if (csn_a !== level) begin
            checks++; errors++;
            $display("[TB] FAIL wait_csn_a: CSN=%b after %0d cycles, required %b", csn_a, limit, level);
            at = -1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (csn_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_csn: got %b, required 1", csn_a); end
        checks++; if (sclk_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b, required 0", sclk_a); end
        checks++; if (mosi_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b, required 0", mosi_a); end
        checks++; if ({x_a, y_a, z_a} !== 36'd0) begin errors++; $display("[TB] FAIL reset_xyz: got %h %h %h, required 0", x_a, y_a, z_a); end
        checks++; if (valid_a !== 1'b0 || cfg_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: valid=%b cfg_done=%b, required 0 0", valid_a, cfg_a); end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        int t;
        wait_csn_a(1'b0, 300, t);
        checks++; if (t !== 100) begin errors++; $display("[TB] FAIL startup_csn_fall: cycle %0d, required 100", t); end
        checks++; if (cfg_a !== 1'b0) begin errors++; $display("[TB] FAIL startup_cfg_done: got %b, required 0", cfg_a); end
    endtask

    task automatic test_config();
        int t0, first_rise, n;
        logic early_cfg;
        t0 = cyc; first_rise = -1; n = 0; early_cfg = 1'b0;
        while (csn_a === 1'b0 && n < 200) begin
            if (sclk_a === 1'b1 && first_rise < 0) first_rise = cyc;
            if (cfg_a !== 1'b0) early_cfg = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++; if (cyc - t0 !== 104) begin errors++; $display("[TB] FAIL cfg_csn_low: %0d cycles, required 104", cyc - t0); end
        checks++; if (first_rise - t0 !== 6) begin errors++; $display("[TB] FAIL cfg_first_sclk: offset %0d, required 6", first_rise - t0); end
        checks++; if (mosi_cap_a !== 24'h0A2D02) begin errors++; $display("[TB] FAIL cfg_bytes: got %h, required 0a2d02", mosi_cap_a); end
        checks++; if (rises_a !== 24) begin errors++; $display("[TB] FAIL cfg_sclk_rises: got %0d, required 24", rises_a); end
        checks++; if (early_cfg !== 1'b0 || cfg_a !== 1'b1) begin errors++; $display("[TB] FAIL cfg_done_edge: early=%b now=%b, required 0 1", early_cfg, cfg_a); end
    endtask

    task automatic test_burst_read();
        int t0, n, vcount;
        wait_csn_a(1'b0, 50, t0);
        checks++; if (t0 !== 208) begin errors++; $display("[TB] FAIL read_start: cycle %0d, required 208", t0); end
        n = 0; vcount = 0;
        while (csn_a === 1'b0 && n < 400) begin
            if (valid_a === 1'b1 || {x_a, y_a, z_a} !== 36'd0) vcount++;
            @(negedge clk);
            n++;
        end
        frame_a = 64'h0000_FF07_0108_55FA;
        checks++; if (cyc - t0 !== 264) begin errors++; $display("[TB] FAIL read_csn_low: %0d cycles, required 264", cyc - t0); end
        checks++; if (vcount !== 0) begin errors++; $display("[TB] FAIL read_early_update: %0d cycles, required 0", vcount); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("[TB] FAIL read_valid: got %b, required 1", valid_a); end
        checks++; if (x_a !== 12'h234) begin errors++; $display("[TB] FAIL read_x: got %h, required 234", x_a); end
        checks++; if (y_a !== 12'hFF0) begin errors++; $display("[TB] FAIL read_y: got %h, required ff0", y_a); end
        checks++; if (z_a !== 12'h800) begin errors++; $display("[TB] FAIL read_z: got %h, required 800", z_a); end
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL read_valid_width: got %b, required 0", valid_a); end
    endtask

    task automatic test_sample_rate();
        int t1, t2, n, unstable;
        n = 0; unstable = 0;
        while (csn_a === 1'b1 && n < 1200) begin
            if (valid_a !== 1'b0 || x_a !== 12'h234 || y_a !== 12'hFF0 || z_a !== 12'h800) unstable++;
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        checks++; if (t1 !== 1208) begin errors++; $display("[TB] FAIL rate_second_fall: cycle %0d, required 1208", t1); end
        n = 0;
        while (csn_a === 1'b0 && n < 400) begin
            if (valid_a !== 1'b0 || x_a !== 12'h234 || y_a !== 12'hFF0 || z_a !== 12'h800) unstable++;
            @(negedge clk);
            n++;
        end
        checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL rate_stable: %0d unstable cycles, required 0", unstable); end
        checks++; if (valid_a !== 1'b1 || {x_a, y_a, z_a} !== {12'h7FF, 12'h801, 12'hA55}) begin
            errors++; $display("[TB] FAIL rate_sample2: valid=%b xyz=%h %h %h, required 1 7ff 801 a55", valid_a, x_a, y_a, z_a);
        end
        wait_csn_a(1'b0, 1100, t2);
        checks++; if (t2 - t1 !== 1000) begin errors++; $display("[TB] FAIL rate_period: %0d cycles, required 1000", t2 - t1); end
    endtask

    task automatic test_short_period();
        checks++; if (falls_b[1] !== 208) begin errors++; $display("[TB] FAIL short_first_read: cycle %0d, required 208", falls_b[1]); end
        checks++; if (falls_b[2] - falls_b[1] !== 268) begin errors++; $display("[TB] FAIL short_period1: %0d, required 268", falls_b[2] - falls_b[1]); end
        checks++; if (falls_b[3] - falls_b[2] !== 268) begin errors++; $display("[TB] FAIL short_period2: %0d, required 268", falls_b[3] - falls_b[2]); end
        checks++; if (falls_b[3] - rises_b[2] !== 4) begin errors++; $display("[TB] FAIL short_gap: %0d, required 4", falls_b[3] - rises_b[2]); end
        checks++; if ({x_b, y_b, z_b} !== {12'h59A, 12'h366, 12'hFFF}) begin
            errors++; $display("[TB] FAIL short_sample: xyz=%h %h %h, required 59a 366 fff", x_b, y_b, z_b);
        end
    endtask

    task automatic test_reset_mid_read();
        int t, n, leaked;
        frame_a = 64'h0000_11F3_2204_3305;
        repeat (180) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (csn_a !== 1'b1 || sclk_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_bus: csn=%b sclk=%b, required 1 0", csn_a, sclk_a); end
        checks++; if ({x_a, y_a, z_a} !== 36'd0 || valid_a !== 1'b0 || cfg_a !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_outputs: xyz=%h %h %h valid=%b cfg=%b, required zeros", x_a, y_a, z_a, valid_a, cfg_a);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_csn_a(1'b0, 300, t);
        checks++; if (t !== 100) begin errors++; $display("[TB] FAIL midreset_restart: cycle %0d, required 100", t); end
        n = 0; leaked = 0;
        while (valid_a !== 1'b1 && n < 600) begin
            if ({x_a, y_a, z_a} !== 36'd0) leaked++;
            @(negedge clk);
            n++;
        end
        checks++; if (cyc !== 472 || leaked !== 0) begin errors++; $display("[TB] FAIL midreset_first_valid: cycle %0d leaked %0d, required 472 0", cyc, leaked); end
        checks++; if ({x_a, y_a, z_a} !== {12'h311, 12'h422, 12'h533}) begin
            errors++; $display("[TB] FAIL midreset_sample: xyz=%h %h %h, required 311 422 533", x_a, y_a, z_a);
        end
    endtask

    initial begin
        $display("[TB] starting adxl362_spi_master bench");
        test_reset();
        test_startup();
        test_config();
        test_burst_read();
        test_sample_rate();
        test_short_period();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
